// File: rtl/mem_stage_if.sv
// Data-memory request bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack bus, stalls upstream until ack, loads MEM/WB.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memops are dropped and raise a one-cycle misalign pulse.
module mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pi4_ADDR,
  input  logic [31:0]  pi4_WD,
  input  logic [4:0]   pi4_MUX,
  input  logic [1:0]   pi4_wb,
  input  logic         pi4_MemRead,
  input  logic         pi4_MemWrite,
  input  logic         pi4_Branch,
  input  logic         pi4_zero,
  mem_stage_if.master  dmem,
  output logic         stall,
  output logic         PCSrc,
  output logic         misalign,
  output logic [1:0]   pi5_wb,
  output logic [31:0]  pi5_RD,
  output logic [31:0]  pi5_ALU,
  output logic [4:0]   pi5_MUX
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        memop, bad_align;
  logic        capture, pass;
  logic [31:0] rd_nxt;

  assign memop = pi4_MemRead | pi4_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign bad_align = memop & (|pi4_ADDR[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    capture   = 1'b0;
    pass      = 1'b0;
    rd_nxt    = 32'd0;
    case (state)
      IDLE: begin
        if (memop && !bad_align) begin
          stall     = 1'b1;
          capture   = 1'b1;
          state_nxt = BUSY;
        end else if (!memop) begin
          pass = 1'b1;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          pass      = 1'b1;
          rd_nxt    = we_q ? 32'd0 : dmem.dmem_rdata;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset abandons any in-flight access; the upstream must not be frozen meanwhile.
    if (rst) begin
      state_nxt = IDLE;
      stall     = 1'b0;
      capture   = 1'b0;
      pass      = 1'b0;
      rd_nxt    = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      misalign <= 1'b0;
      pi5_wb   <= 2'd0;
      pi5_RD   <= 32'd0;
      pi5_ALU  <= 32'd0;
      pi5_MUX  <= 5'd0;
    end else begin
      state    <= state_nxt;
      misalign <= (state == IDLE) && bad_align;
      if (capture) begin
        addr_q  <= pi4_ADDR;
        wdata_q <= pi4_WD;
        we_q    <= pi4_MemWrite;
      end
      // Anything other than a completing op or a non-memory op writes a bubble.
      pi5_wb  <= pass ? pi4_wb   : 2'd0;
      pi5_MUX <= pass ? pi4_MUX  : 5'd0;
      pi5_ALU <= pass ? pi4_ADDR : 32'd0;
      pi5_RD  <= rd_nxt;
    end
  end

  assign dmem.dmem_req   = (state == BUSY);
  assign dmem.dmem_we    = (state == BUSY) & we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign PCSrc = pi4_Branch & pi4_zero & ~stall & ~rst;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pi4_ADDR, pi4_WD;
  logic [4:0]  pi4_MUX;
  logic [1:0]  pi4_wb;
  logic        pi4_MemRead, pi4_MemWrite, pi4_Branch, pi4_zero;
  logic        stall, PCSrc, misalign;
  logic [1:0]  pi5_wb;
  logic [31:0] pi5_RD, pi5_ALU;
  logic [4:0]  pi5_MUX;

  mem_stage_if dmem();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .pi4_ADDR(pi4_ADDR), .pi4_WD(pi4_WD), .pi4_MUX(pi4_MUX), .pi4_wb(pi4_wb),
    .pi4_MemRead(pi4_MemRead), .pi4_MemWrite(pi4_MemWrite),
    .pi4_Branch(pi4_Branch), .pi4_zero(pi4_zero),
    .dmem(dmem),
    .stall(stall), .PCSrc(PCSrc), .misalign(misalign),
    .pi5_wb(pi5_wb), .pi5_RD(pi5_RD), .pi5_ALU(pi5_ALU), .pi5_MUX(pi5_MUX)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding memory transaction at most, plus the expected MEM/WB contents.
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [1:0]  e_wb = '0;
  logic [31:0] e_rd = '0, e_alu = '0;
  logic [4:0]  e_mux = '0;
  bit          e_mis = 1'b0;
  bit          last_stall = 1'b0;

  always @(negedge clk) begin
    bit op, trap, ack, ex_stall;
    op  = pi4_MemRead | pi4_MemWrite;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = op && (pi4_ADDR % 4 != 0);
`else
    trap = 1'b0;
`endif
    ack = dmem.dmem_ack;
    if (rst)         ex_stall = 1'b0;
    else if (m_busy) ex_stall = !ack;
    else             ex_stall = op && !trap;

    if (m_on) begin
      check("m_stall",   32'(stall), 32'(ex_stall));
      check("m_PCSrc",   32'(PCSrc), 32'(!rst && pi4_Branch && pi4_zero && !ex_stall));
      check("m_req",     32'(dmem.dmem_req), 32'(m_busy));
      check("m_we",      32'(dmem.dmem_we),  32'(m_busy && m_we));
      if (m_busy) begin
        check("m_addr",  dmem.dmem_addr,  m_addr);
        check("m_wdata", dmem.dmem_wdata, m_wd);
      end
      check("m_pi5_wb",  32'(pi5_wb),  32'(e_wb));
      check("m_pi5_RD",  pi5_RD,       e_rd);
      check("m_pi5_ALU", pi5_ALU,      e_alu);
      check("m_pi5_MUX", 32'(pi5_MUX), 32'(e_mux));
      check("m_misalign", 32'(misalign), 32'(e_mis));
    end
    last_stall = ex_stall;

    // Outcome of the coming clock edge.
    if (rst) begin
      m_busy = 0; m_we = 0; m_addr = 0; m_wd = 0;
      e_wb = 0; e_rd = 0; e_alu = 0; e_mux = 0; e_mis = 0;
    end else begin
      e_mis = 0;
      e_wb = 0; e_rd = 0; e_alu = 0; e_mux = 0;
      if (!m_busy) begin
        if (!op) begin
          e_wb = pi4_wb; e_mux = pi4_MUX; e_alu = pi4_ADDR;
        end else if (trap) begin
          e_mis = 1;
        end else begin
          m_busy = 1; m_addr = pi4_ADDR; m_wd = pi4_WD; m_we = pi4_MemWrite;
        end
      end else if (ack) begin
        e_wb = pi4_wb; e_mux = pi4_MUX; e_alu = pi4_ADDR;
        e_rd = m_we ? 32'd0 : dmem.dmem_rdata;
        m_busy = 0;
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] mux,
                       input logic [1:0] wb, input logic rd, input logic wr,
                       input logic br, input logic z);
    pi4_ADDR = a; pi4_WD = wd; pi4_MUX = mux; pi4_wb = wb;
    pi4_MemRead = rd; pi4_MemWrite = wr; pi4_Branch = br; pi4_zero = z;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;

    // Reset state
    cyc();
    m_on = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_PCSrc", 32'(PCSrc), 32'd0);
    check("rst_pi5_ALU", pi5_ALU, 32'd0);
    check("rst_pi5_wb", 32'(pi5_wb), 32'd0);
    check("rst_req", 32'(dmem.dmem_req), 32'd0);

    // Non-memory pass-through
    cyc(); rst = 1'b0;
    drive(32'h10, 32'h0, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pass_stall", 32'(stall), 32'd0);
    cyc(); drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pass_ALU", pi5_ALU, 32'h10);
    check("pass_MUX", 32'(pi5_MUX), 32'd5);
    check("pass_wb", 32'(pi5_wb), 32'd2);

    // Load with two waiting BUSY cycles, ack in the third
    cyc(); drive(32'h40, 32'h0, 5'd7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      dmem.dmem_ack = (i == 3);
      dmem.dmem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      stalls += int'(stall);
      if (i > 0) begin
        check("ld_req", 32'(dmem.dmem_req), 32'd1);
        check("ld_addr", dmem.dmem_addr, 32'h40);
      end
      cyc();
    end
    dmem.dmem_ack = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_stall_cycles", 32'(stalls), 32'd3);
    check("ld_RD", pi5_RD, 32'hDEADBEEF);
    check("ld_ALU", pi5_ALU, 32'h40);
    check("ld_MUX", 32'(pi5_MUX), 32'd7);

    // Store acked immediately
    cyc(); drive(32'h8, 32'h1234, 5'd3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      dmem.dmem_ack = (i == 1);
      dmem.dmem_rdata = 32'hAAAA5555;
      @(negedge clk);
      stalls += int'(stall);
      if (i == 1) begin
        check("st_we", 32'(dmem.dmem_we), 32'd1);
        check("st_wdata", dmem.dmem_wdata, 32'h1234);
      end
      cyc();
    end
    dmem.dmem_ack = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("st_stall_cycles", 32'(stalls), 32'd1);
    check("st_RD", pi5_RD, 32'd0);
    check("st_wb", 32'(pi5_wb), 32'd3);

    // Branch resolution with and without stall
    cyc(); drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("br_taken", 32'(PCSrc), 32'd1);
    cyc(); drive(32'h20, 32'h0, 5'd1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("br_stalled", 32'(PCSrc), 32'd0);
    cyc(); dmem.dmem_ack = 1'b1;
    @(negedge clk);
    check("br_on_ack", 32'(PCSrc), 32'd1);
    cyc(); dmem.dmem_ack = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while BUSY, late ack ignored
    cyc(); drive(32'h80, 32'h0, 5'd9, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    @(negedge clk);
    check("rb_req_busy", 32'(dmem.dmem_req), 32'd1);
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("rb_stall_in_rst", 32'(stall), 32'd0);
    cyc(); rst = 1'b0; dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFFFFFF;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rb_req", 32'(dmem.dmem_req), 32'd0);
    check("rb_pi5_RD", pi5_RD, 32'd0);
    check("rb_pi5_MUX", 32'(pi5_MUX), 32'd0);
    cyc(); dmem.dmem_ack = 1'b0;
    @(negedge clk);
    check("rb_ack_ignored", pi5_RD, 32'd0);

    // Misaligned load
    cyc(); drive(32'h42, 32'h0, 5'd4, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    check("mis_req", 32'(dmem.dmem_req), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    cyc(); drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_wb", 32'(pi5_wb), 32'd0);
    check("mis_req2", 32'(dmem.dmem_req), 32'd0);
    cyc();
    @(negedge clk);
    check("mis_pulse_end", 32'(misalign), 32'd0);
`else
    cyc(); dmem.dmem_ack = 1'b1;
    @(negedge clk);
    check("mis_addr_issued", dmem.dmem_addr, 32'h42);
    check("mis_tied", 32'(misalign), 32'd0);
    cyc(); dmem.dmem_ack = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic; upstream holds its inputs while stalled
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        logic [31:0] a;
        int kind;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        kind = $urandom_range(0, 5);
        drive(a, $urandom, 5'($urandom), 2'($urandom),
              kind == 1 || kind == 2 || kind == 4,
              kind == 3 || kind == 4,
              1'($urandom), 1'($urandom));
      end
      dmem.dmem_ack = dmem.dmem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      dmem.dmem_rdata = $urandom;
    end

    cyc();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
